// File: rtl/regfile_write_arbiter.sv
// Two-source writeback arbiter for the register file: 1-entry buffers, round-robin grant with
// same-destination ordering, registered write port. Optional Busy scoreboard: `REGARB_BUSY_EN.
module regfile_write_arbiter #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   A_Valid,
   output logic                   A_Ready,
   input  logic [REG_AW-1:0]      A_DR,
   input  logic [DATA_W-1:0]      A_Data,
   input  logic                   B_Valid,
   output logic                   B_Ready,
   input  logic [REG_AW-1:0]      B_DR,
   input  logic [DATA_W-1:0]      B_Data,
   output logic                   Ld_REG,
   output logic [REG_AW-1:0]      DR,
   output logic [DATA_W-1:0]      Data,
   output logic                   Grant_B,
   output logic [2**REG_AW-1:0]   Busy
);

   localparam int NREG = 2**REG_AW;

   logic              a_full_q, a_full_d;
   logic [REG_AW-1:0] a_dr_q, a_dr_d;
   logic [DATA_W-1:0] a_data_q, a_data_d;
   logic              b_full_q, b_full_d;
   logic [REG_AW-1:0] b_dr_q, b_dr_d;
   logic [DATA_W-1:0] b_data_q, b_data_d;
   logic              rr_b_q, rr_b_d;
   logic              age_b_q, age_b_d;
   logic              ld_reg_q, ld_reg_d;
   logic [REG_AW-1:0] dr_q, dr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              grant_b_q, grant_b_d;

   logic acc_a, acc_b;
   logic grant_a, grant_b;

   assign acc_a = A_Valid & ~a_full_q;
   assign acc_b = B_Valid & ~b_full_q;

   // Same destination must retire in arrival order, so the age bit overrides round-robin there.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      rr_b_d  = rr_b_q;
      if (a_full_q && b_full_q) begin
         if (a_dr_q != b_dr_q) begin
            grant_a = ~rr_b_q;
            grant_b = rr_b_q;
            rr_b_d  = ~rr_b_q;
         end else begin
            grant_a = ~age_b_q;
            grant_b = age_b_q;
         end
      end else begin
         grant_a = a_full_q;
         grant_b = b_full_q;
      end
   end

   always_comb begin
      a_full_d = a_full_q;
      a_dr_d   = a_dr_q;
      a_data_d = a_data_q;
      b_full_d = b_full_q;
      b_dr_d   = b_dr_q;
      b_data_d = b_data_q;
      age_b_d  = age_b_q;
      if (grant_a) a_full_d = 1'b0;
      if (grant_b) b_full_d = 1'b0;
      if (acc_a) begin
         a_full_d = 1'b1;
         a_dr_d   = A_DR;
         a_data_d = A_Data;
      end
      if (acc_b) begin
         b_full_d = 1'b1;
         b_dr_d   = B_DR;
         b_data_d = B_Data;
      end
      if (acc_a && acc_b)
         age_b_d = 1'b0;
      else if (acc_a && b_full_q)
         age_b_d = 1'b1;
      else if (acc_b && a_full_q)
         age_b_d = 1'b0;
   end

   // DR/Data hold their last value between writes; only Ld_REG qualifies them.
   always_comb begin
      ld_reg_d  = grant_a | grant_b;
      dr_d      = dr_q;
      data_d    = data_q;
      grant_b_d = grant_b_q;
      if (grant_a) begin
         dr_d      = a_dr_q;
         data_d    = a_data_q;
         grant_b_d = 1'b0;
      end else if (grant_b) begin
         dr_d      = b_dr_q;
         data_d    = b_data_q;
         grant_b_d = 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         a_full_q  <= 1'b0;
         a_dr_q    <= '0;
         a_data_q  <= '0;
         b_full_q  <= 1'b0;
         b_dr_q    <= '0;
         b_data_q  <= '0;
         rr_b_q    <= 1'b0;
         age_b_q   <= 1'b0;
         ld_reg_q  <= 1'b0;
         dr_q      <= '0;
         data_q    <= '0;
         grant_b_q <= 1'b0;
      end else begin
         a_full_q  <= a_full_d;
         a_dr_q    <= a_dr_d;
         a_data_q  <= a_data_d;
         b_full_q  <= b_full_d;
         b_dr_q    <= b_dr_d;
         b_data_q  <= b_data_d;
         rr_b_q    <= rr_b_d;
         age_b_q   <= age_b_d;
         ld_reg_q  <= ld_reg_d;
         dr_q      <= dr_d;
         data_q    <= data_d;
         grant_b_q <= grant_b_d;
      end
   end

   assign A_Ready = ~a_full_q;
   assign B_Ready = ~b_full_q;
   assign Ld_REG  = ld_reg_q;
   assign DR      = dr_q;
   assign Data    = data_q;
   assign Grant_B = grant_b_q;

`ifdef REGARB_BUSY_EN
   logic [NREG-1:0] busy_q, busy_d;

   // Built from next-state so Busy changes on the same edge as the buffers and Ld_REG.
   always_comb begin
      busy_d = '0;
      if (a_full_d) busy_d[a_dr_d] = 1'b1;
      if (b_full_d) busy_d[b_dr_d] = 1'b1;
      if (ld_reg_d) busy_d[dr_d]   = 1'b1;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   assign Busy = busy_q;
`else
   assign Busy = {NREG{1'b0}};
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter against a sequence-numbered
// transaction model; Busy expectations follow `REGARB_BUSY_EN.
module tb_regfile_write_arbiter;

   logic        Clk;
   logic        Reset;
   logic        A_Valid, B_Valid;
   logic        A_Ready, B_Ready;
   logic [2:0]  A_DR, B_DR;
   logic [15:0] A_Data, B_Data;
   logic        Ld_REG;
   logic [2:0]  DR;
   logic [15:0] Data;
   logic        Grant_B;
   logic [7:0]  Busy;

   regfile_write_arbiter #(.DATA_W(16), .REG_AW(3)) dut (
      .Clk(Clk), .Reset(Reset),
      .A_Valid(A_Valid), .A_Ready(A_Ready), .A_DR(A_DR), .A_Data(A_Data),
      .B_Valid(B_Valid), .B_Ready(B_Ready), .B_DR(B_DR), .B_Data(B_Data),
      .Ld_REG(Ld_REG), .DR(DR), .Data(Data), .Grant_B(Grant_B), .Busy(Busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      bit          full;
      logic [2:0]  dr;
      logic [15:0] data;
      int          seq;
   } slot_t;

   int checks = 0;
   int errors = 0;

   slot_t       m_a, m_b;
   bit          m_rr_b;
   int          seq_ctr;
   bit          e_ld;
   logic [2:0]  e_dr;
   logic [15:0] e_data;
   bit          e_gb;
   logic [15:0] rf_obs [8];
   int          acc_count, wr_count;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_busy();
      logic [7:0] b = 8'h00;
`ifdef REGARB_BUSY_EN
      if (m_a.full) b[m_a.dr] = 1'b1;
      if (m_b.full) b[m_b.dr] = 1'b1;
      if (e_ld)     b[e_dr]   = 1'b1;
`endif
      return b;
   endfunction

   task automatic model_reset();
      m_a = '{0, 3'd0, 16'h0, 0};
      m_b = '{0, 3'd0, 16'h0, 0};
      m_rr_b = 0; seq_ctr = 0; e_ld = 0; e_gb = 0;
      e_dr = 3'd0; e_data = 16'h0;
   endtask

   // One clock edge of transactions: pick the winner among held writes, then take new ones.
   task automatic model_step(input bit av, input logic [2:0] adr, input logic [15:0] ad,
                             input bit bv, input logic [2:0] bdr, input logic [15:0] bd);
      bit take_a, take_b, win_a, win_b;
      take_a = av && !m_a.full;
      take_b = bv && !m_b.full;
      win_a = 0; win_b = 0;
      if (m_a.full && m_b.full) begin
         if (m_a.dr != m_b.dr) begin
            if (m_rr_b) win_b = 1; else win_a = 1;
            m_rr_b = !m_rr_b;
         end else if (m_a.seq < m_b.seq) win_a = 1;
         else win_b = 1;
      end else if (m_a.full) win_a = 1;
      else if (m_b.full) win_b = 1;
      e_ld = win_a || win_b;
      if (win_a) begin e_dr = m_a.dr; e_data = m_a.data; e_gb = 0; m_a.full = 0; end
      if (win_b) begin e_dr = m_b.dr; e_data = m_b.data; e_gb = 1; m_b.full = 0; end
      if (take_a) begin m_a = '{1, adr, ad, seq_ctr}; seq_ctr++; end
      if (take_b) begin m_b = '{1, bdr, bd, seq_ctr}; seq_ctr++; end
   endtask

   task automatic step_cycle(input bit av, input logic [2:0] adr, input logic [15:0] ad,
                             input bit bv, input logic [2:0] bdr, input logic [15:0] bd);
      A_Valid = av; A_DR = adr; A_Data = ad;
      B_Valid = bv; B_DR = bdr; B_Data = bd;
      if (av && A_Ready) acc_count++;
      if (bv && B_Ready) acc_count++;
      @(posedge Clk);
      #1;
      model_step(av, adr, ad, bv, bdr, bd);
      if (Ld_REG) begin rf_obs[DR] = Data; wr_count++; end
      check_output("ld_reg", 32'(Ld_REG), 32'(e_ld));
      if (e_ld) begin
         check_output("dr", 32'(DR), 32'(e_dr));
         check_output("data", 32'(Data), 32'(e_data));
         check_output("grant_b", 32'(Grant_B), 32'(e_gb));
      end
      check_output("a_ready", 32'(A_Ready), 32'(!m_a.full));
      check_output("b_ready", 32'(B_Ready), 32'(!m_b.full));
      check_output("busy", 32'(Busy), 32'(model_busy()));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step_cycle(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_output({tag, "_ld"}, 32'(Ld_REG), 32'd0);
      check_output({tag, "_dr"}, 32'(DR), 32'd0);
      check_output({tag, "_data"}, 32'(Data), 32'd0);
      check_output({tag, "_gb"}, 32'(Grant_B), 32'd0);
      check_output({tag, "_busy"}, 32'(Busy), 32'd0);
      check_output({tag, "_ardy"}, 32'(A_Ready), 32'd1);
      check_output({tag, "_brdy"}, 32'(B_Ready), 32'd1);
   endtask

   initial begin
      logic [7:0] busy7;
`ifdef REGARB_BUSY_EN
      busy7 = 8'h80;
`else
      busy7 = 8'h00;
`endif
      Reset = 1'b0;
      A_Valid = 0; A_DR = 0; A_Data = 0;
      B_Valid = 0; B_DR = 0; B_Data = 0;
      acc_count = 0; wr_count = 0;
      for (int r = 0; r < 8; r++) rf_obs[r] = 16'h0;
      model_reset();
      #12;
      check_reset_outputs("por");
      @(negedge Clk) Reset = 1'b1;
      @(posedge Clk); #1;

      // A-only write
      step_cycle(1, 3'd3, 16'h1234, 0, 3'd0, 16'h0);
      step_cycle(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
      check_output("aonly_ld", 32'(Ld_REG), 32'd1);
      check_output("aonly_dr", 32'(DR), 32'd3);
      check_output("aonly_data", 32'(Data), 32'h1234);
      check_output("aonly_gb", 32'(Grant_B), 32'd0);
      step_cycle(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
      check_output("aonly_pulse", 32'(Ld_REG), 32'd0);

      // Busy for DR=7
      step_cycle(1, 3'd7, 16'h7777, 0, 3'd0, 16'h0);
      check_output("busy7_held", 32'(Busy), 32'(busy7));
      step_cycle(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
      check_output("busy7_ld", 32'(Busy), 32'(busy7));
      step_cycle(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
      check_output("busy7_clear", 32'(Busy), 32'h00);

      // Contention, rr starts at A
      step_cycle(1, 3'd1, 16'hAAAA, 1, 3'd2, 16'hBBBB);
      step_cycle(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
      check_output("rrA_first_dr", 32'(DR), 32'd1);
      check_output("rrA_first_gb", 32'(Grant_B), 32'd0);
      step_cycle(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
      check_output("rrA_second_data", 32'(Data), 32'hBBBB);
      check_output("rrA_second_ld", 32'(Ld_REG), 32'd1);
      step_cycle(1, 3'd1, 16'hAAAA, 1, 3'd2, 16'hBBBB);
      step_cycle(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
      check_output("rrB_first_gb", 32'(Grant_B), 32'd1);
      check_output("rrB_first_data", 32'(Data), 32'hBBBB);
      step_cycle(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
      check_output("rrB_second_data", 32'(Data), 32'hAAAA);
      idle(1);

      // Same-DR ordering
      step_cycle(0, 3'd0, 16'h0, 1, 3'd5, 16'h0001);
      step_cycle(1, 3'd5, 16'h0002, 0, 3'd0, 16'h0);
      check_output("samedr_first", 32'(Data), 32'h0001);
      step_cycle(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
      check_output("samedr_second", 32'(Data), 32'h0002);
      idle(1);
      check_output("samedr_r5", 32'(rf_obs[5]), 32'h0002);

      // Backpressure: A_Valid held high
      acc_count = 0; wr_count = 0;
      for (int i = 0; i < 8; i++) begin
         check_output("bp_ready", 32'(A_Ready), 32'((i % 2) == 0));
         step_cycle(1, 3'(i), 16'(16'h5000 + i), 0, 3'd0, 16'h0);
      end
      idle(3);
      check_output("bp_count", 32'(wr_count), 32'(acc_count));

      // Random traffic with narrow DR range to provoke same-destination collisions
      for (int i = 0; i < 400; i++) begin
         step_cycle(bit'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 3)), 16'($urandom),
                    bit'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 3)), 16'($urandom));
      end

      // Reset mid-traffic
      step_cycle(1, 3'd6, 16'hDEAD, 1, 3'd4, 16'hBEEF);
      Reset = 1'b0;
      #2;
      check_reset_outputs("midrst");
      model_reset();
      A_Valid = 0; B_Valid = 0;
      @(negedge Clk) Reset = 1'b1;
      idle(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
